// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data-memory handshake, store lane steering, load align/extend.
// Optional MISALIGN_TRAP_EN: trap misaligned H/W accesses without issuing a request.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_out,
  output logic        mem_stall,
  output logic        misalign
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [3:0]  dm_be_q;
  logic [31:0] dm_wdata_q;
  logic [31:0] dm_out_q;
  logic        misalign_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lsb_q;

  logic        start;
  logic        is_byte;
  logic        is_half;
  logic        mis_trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign start   = mem_read | mem_write;
  // funct3[2] only selects signedness, so BU/HU share the B/H size decode
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign mis_trap = (is_half & addr[0]) | (!is_byte & !is_half & (addr[1:0] != 2'b00));
`else
  assign mis_trap = 1'b0;
`endif

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    if (is_byte) begin
      st_be    = 4'b0001 << addr[1:0];
      st_wdata = {4{wdata[7:0]}};
    end else if (is_half) begin
      st_be    = 4'b0011 << {addr[1], 1'b0};
      st_wdata = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    unique case (lsb_q)
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = lsb_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    if (funct3_q[1:0] == 2'b00) begin
      ld_result = {{24{ld_byte[7] & !funct3_q[2]}}, ld_byte};
    end else if (funct3_q[1:0] == 2'b01) begin
      ld_result = {{16{ld_half[15] & !funct3_q[2]}}, ld_half};
    end else begin
      ld_result = dm_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
      dm_out_q   <= '0;
      misalign_q <= 1'b0;
      funct3_q   <= '0;
      lsb_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          misalign_q <= 1'b0;
          if (start) begin
            if (mis_trap) begin
              misalign_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              dm_req_q   <= 1'b1;
              dm_we_q    <= mem_write;
              dm_addr_q  <= {addr[31:2], 2'b00};
              dm_be_q    <= mem_write ? st_be : 4'b0000;
              dm_wdata_q <= st_wdata;
              funct3_q   <= funct3;
              lsb_q      <= addr[1:0];
              state_q    <= StWait;
            end
          end
        end
        StWait: begin
          if (dm_ack) begin
            dm_req_q <= 1'b0;
            state_q  <= StDone;
            if (!dm_we_q) begin
              dm_out_q <= ld_result;
            end
          end
        end
        StDone: begin
          misalign_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_stall = ((state_q == StIdle) & start) | (state_q == StWait);
  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_be     = dm_be_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_out    = dm_out_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized ops against an arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] dm_out;
  logic        mem_stall, misalign;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_out = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_out(dm_out), .mem_stall(mem_stall), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1 with the unit in IDLE.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int k);
    int unsigned sz, shift;
    bit trap;
    logic [31:0] exp_be, exp_wd, v;
    sz    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    shift = (sz == 1) ? a % 4 : (sz == 2) ? (a % 4) / 2 * 2 : 0;
`ifdef MISALIGN_TRAP_EN
    trap = (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
`else
    trap = 1'b0;
`endif
    exp_be = wr ? ((sz == 1) ? (32'd1 << shift) : (sz == 2) ? (32'd3 << shift) : 32'd15) : 32'd0;
    exp_wd = (sz == 1) ? (wd % 256) * 32'h01010101 :
             (sz == 2) ? (wd % 65536) * 32'h00010001 : wd;
    v = word >> (8 * shift);
    if (sz == 1) begin
      v = v % 256;
      if (f3 < 4 && v >= 128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (f3 < 4 && v >= 32768) v = v - 32'd65536;
    end
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    check("stall_issue", mem_stall, 1);
    check("req_issue", dm_req, 0);
    @(posedge clk); #1;
    if (!trap) begin
      for (int i = 1; i <= k; i++) begin
        dm_ack   = (i == k);
        dm_rdata = (i == k) ? word : $urandom;
        @(negedge clk);
        check("req_wait", dm_req, 1);
        check("stall_wait", mem_stall, 1);
        check("addr_wait", dm_addr, a - a % 4);
        check("we_wait", dm_we, wr);
        check("be_wait", dm_be, exp_be);
        if (wr) check("wdata_wait", dm_wdata, exp_wd);
        @(posedge clk); #1;
      end
      if (rd && !wr) model_out = v;
    end
    dm_ack = $urandom % 2; dm_rdata = $urandom;
    @(negedge clk);
    check("stall_done", mem_stall, 0);
    check("req_done", dm_req, 0);
    check("misalign_done", misalign, trap);
    check("dm_out_done", dm_out, model_out);
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; dm_ack = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_read = 0; mem_write = 0; dm_ack = $urandom % 2; dm_rdata = $urandom;
      @(negedge clk);
      check("stall_idle", mem_stall, 0);
      check("req_idle", dm_req, 0);
      check("misalign_idle", misalign, 0);
      check("dm_out_idle", dm_out, model_out);
      @(posedge clk); #1;
    end
    dm_ack = 0;
  endtask

  initial begin
    rst_n = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
    dm_ack = 0; dm_rdata = 0;
    #12;
    check("rst_req", dm_req, 0);
    check("rst_we", dm_we, 0);
    check("rst_addr", dm_addr, 0);
    check("rst_be", dm_be, 0);
    check("rst_wdata", dm_wdata, 0);
    check("rst_out", dm_out, 0);
    check("rst_misalign", misalign, 0);
    check("rst_stall", mem_stall, 0);
    @(posedge clk); #1; rst_n = 1;
    idle_cycles(2);

    run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);        // SW
    run_op(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 2);        // SB
    run_op(1, 0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 1);        // LB
    check("lb_value", dm_out, 32'hFFFFFFF4);
    run_op(1, 0, 3'b100, 32'h102, 32'h0, 32'h12F45678, 1);        // LBU
    check("lbu_value", dm_out, 32'h000000F4);
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h12F45678, 1);        // LH
    check("lh_value", dm_out, 32'h000012F4);
    run_op(1, 0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 5);        // LW long wait
    run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h11111111, 1);        // back-to-back
    run_op(1, 0, 3'b010, 32'h304, 32'h0, 32'h22222222, 1);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h33333333, 1);        // misaligned LW

    // Reset during WAIT.
    mem_read = 1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0; #1;
    check("rst_wait_req", dm_req, 0);
    check("rst_wait_out", dm_out, 0);
    mem_read = 0; model_out = 0;
    @(posedge clk); #1; rst_n = 1;
    idle_cycles(1);

    for (int n = 0; n < 200; n++) begin
      int unsigned kind;
      kind = $urandom % 3;
      run_op(kind != 1, kind != 0, 3'($urandom % 8), $urandom, $urandom, $urandom,
             1 + $urandom % 4);
      if ($urandom % 4 == 0) idle_cycles(1 + $urandom % 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit of the five-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register: accepts the memory-op fields of the instruction in MEM, drives a variable-latency data memory over a req/ack handshake, and aligns and extends load data into `dm_out`, which feeds the MEM/WB `DM_out` input. Raises `mem_stall` to freeze the front of the pipeline and the MEM/WB enable while an access is outstanding.

## Interface
- No parameters; data/address width fixed at 32, byte enables at 4.
- `clk` in 1: pipeline clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: instruction in MEM is a load.
- `mem_write` in 1: instruction in MEM is a store; wins if both set.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others are treated as W.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data, rs2 value, LSB-justified.
- `dm_req` out 1: memory request, held until ack.
- `dm_we` out 1: request is a write.
- `dm_addr` out 32: `{addr[31:2],2'b00}`.
- `dm_be` out 4: byte enables; writes only.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ack` in 1: memory completes the current request.
- `dm_rdata` in 32: read word, valid with `dm_ack`.
- `dm_out` out 32: aligned and extended load result.
- `mem_stall` out 1: hold PC, IF/ID, ID/EX, EX/MEM; deassert MEM/WB `en`.
- `misalign` out 1: misaligned access flag; constant 0 unless macro enabled.

## Operation
- States: IDLE, WAIT, DONE. `start = mem_read|mem_write` in IDLE.
- IDLE & start: latch `dm_we`, `dm_addr`, `dm_be`, `dm_wdata`, `funct3`, `addr[1:0]`; set `dm_req`=1; go to WAIT.
- IDLE & !start: stay in IDLE; no request.
- WAIT & !dm_ack: hold all `dm_*` outputs stable.
- WAIT & dm_ack: clear `dm_req`; go to DONE.
- WAIT & dm_ack & load: capture the extended result into `dm_out`.
- DONE: always go to IDLE. The pipeline advances at the end of DONE, so the next instruction is seen in the following IDLE cycle.
- `mem_stall` (combinational) = (IDLE & start) | WAIT. It is 0 in DONE and whenever the MEM instruction is not a memory op.
- Store `dm_be`:
  - B: `4'b0001<<addr[1:0]`.
  - H: `4'b0011<<{addr[1],1'b0}`.
  - W: `4'b1111`.
- Store `dm_wdata`:
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: `wdata`.
- Load lane selection:
  - Byte: lane `addr[1:0]`.
  - Half: lane `addr[1]`.
- Load extension: B/H sign-extend; BU/HU zero-extend.
- `dm_out` updates only when a load completes. It holds across stores and non-memory instructions.
- `dm_ack` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_be`=0, `dm_wdata`=0, `dm_out`=0, `misalign`=0.
- Memory op in IDLE at cycle N:
  - `dm_req` is high from N+1.
  - Ack at cycle N+k (k≥1) makes `dm_out` valid and the state DONE at N+k+1.
  - `mem_stall` is high for cycles N..N+k.
- Minimum occupancy is 3 cycles (ack in the first WAIT cycle).
- Back-to-back memory ops: the second op is issued from the IDLE cycle directly after DONE; no extra bubble.
- An `rst_n` assertion mid-WAIT returns the unit to IDLE immediately, drops `dm_req`, and clears `dm_out`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A misaligned H (`addr[0]`=1) or W (`addr[1:0]`≠0) access in IDLE issues no request.
  - The unit goes straight to DONE with `misalign`=1 for that one cycle.
  - `mem_stall` is high only during the IDLE cycle; `dm_out` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied 0.
  - Low address bits beyond lane selection are ignored, and the access proceeds word-aligned.

## Test plan
- SW `addr=0x100`, `wdata=0xDEADBEEF`, ack after 1 wait cycle -> `dm_be=1111`, `dm_addr=0x100`, `mem_stall` high for 2 cycles then low for 1 DONE cycle, `dm_out` unchanged.
- SB `addr=0x103`, `wdata=0x000000A5` -> `dm_be=1000`, `dm_wdata=0xA5A5A5A5`.
- LB `addr=0x102`, rdata `0x12F45678` -> `dm_out=0xFFFFFFF4`; LBU at the same address -> `0x000000F4`; LH `addr=0x102` -> `0x000012F4`.
- LW with `dm_ack` withheld for 5 cycles -> `dm_req` and `dm_addr` held stable, `mem_stall` high for 6 cycles. Then deassert `rst_n` during WAIT on a retry -> `dm_req`=0 and state IDLE asynchronously.
- Two consecutive loads with immediate ack -> 3 cycles each, second `dm_req` rises exactly 1 cycle after the first DONE.
- With `MISALIGN_TRAP_EN`: LW `addr=0x101` -> no `dm_req`, `misalign`=1 for 1 cycle, `dm_out` unchanged. Without the macro -> request issued to `dm_addr=0x100`.
